register_write_arbiter: RTL and testbench

//   Round-robin arbiter that merges NUM_REQ valid/ready write requesters onto
//   the single en/din write port of a downstream enable register.

---
 rtl/register_write_arbiter_pkg.sv | 12 +
 rtl/register_write_arbiter_if.sv | 28 ++
 rtl/register_write_arbiter_rr_pick.sv | 38 +++
 rtl/register_write_arbiter.sv | 72 +++++++
 tb/tb_register_write_arbiter.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/register_write_arbiter_pkg.sv
// Shared round-robin helpers: index width and pointer wrap.
package register_write_arbiter_pkg;

    function automatic int src_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int rr_next(input int ptr, input int n);
        return (ptr + 1 >= n) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/register_write_arbiter_if.sv
// Requester valid/ready bundle, stall input and registered write port.
interface register_write_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32
);
    import register_write_arbiter_pkg::*;

    localparam int SRC_W = src_w(NUM_REQ);

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     wr_stall;
    logic                     wr_en;
    logic [WIDTH-1:0]         wr_data;
    logic [SRC_W-1:0]         wr_src;

    modport master (
        output req_valid, req_data, wr_stall,
        input  req_ready, wr_en, wr_data, wr_src
    );

    modport slave (
        input  req_valid, req_data, wr_stall,
        output req_ready, wr_en, wr_data, wr_src
    );

endinterface

// File: rtl/register_write_arbiter_rr_pick.sv
// Combinational round-robin pick: first valid index at or after ptr, wrapping.
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     valid,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             any_valid
);

    logic [N-1:0]   hi_mask;
    logic [2*N-1:0] dbl;
    logic           found;
    int             sel;

    // Lower copy keeps only indices >= ptr; upper copy supplies the wrap.
    always_comb begin
        hi_mask   = {N{1'b1}} << ptr;
        dbl       = {valid, valid & hi_mask};
        found     = 1'b0;
        sel       = 0;
        for (int i = 0; i < 2*N; i++) begin
            if (!found && dbl[i]) begin
                found = 1'b1;
                sel   = i % N;
            end
        end
        grant = '0;
        for (int j = 0; j < N; j++) begin
            grant[j] = found && (sel == j);
        end
        idx       = IDX_W'(sel);
        any_valid = |valid;
    end

endmodule

// File: rtl/register_write_arbiter.sv
// Round-robin merge of NUM_REQ write requesters onto one registered en/din port.
module register_write_arbiter
    import register_write_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32
) (
    input logic                    clk,
    input logic                    rst,
    register_write_arbiter_if.slave bus
);

    localparam int SRC_W = src_w(NUM_REQ);

    logic [SRC_W-1:0]   ptr_q, ptr_d;
    logic               wr_en_q, wr_en_d;
    logic [WIDTH-1:0]   wr_data_q, wr_data_d;
    logic [SRC_W-1:0]   wr_src_q, wr_src_d;

    logic [NUM_REQ-1:0] grant;
    logic [SRC_W-1:0]   pick;
    logic               any_valid;
    logic               grant_ok;

    rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (SRC_W)
    ) u_pick (
        .valid     (bus.req_valid),
        .ptr       (ptr_q),
        .grant     (grant),
        .idx       (pick),
        .any_valid (any_valid)
    );

    // Stall only blocks new grants; an already registered write still goes out.
    assign grant_ok = !bus.wr_stall && any_valid;

    always_comb begin
        ptr_d         = ptr_q;
        wr_en_d       = 1'b0;
        wr_data_d     = wr_data_q;
        wr_src_d      = wr_src_q;
        bus.req_ready = '0;
        if (grant_ok) begin
            bus.req_ready = grant;
            wr_en_d       = 1'b1;
            wr_data_d     = bus.req_data[pick*WIDTH +: WIDTH];
            wr_src_d      = pick;
            ptr_d         = SRC_W'(rr_next(int'(pick), NUM_REQ));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
            wr_src_q  <= '0;
        end else begin
            ptr_q     <= ptr_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
            wr_src_q  <= wr_src_d;
        end
    end

    assign bus.wr_en   = wr_en_q;
    assign bus.wr_data = wr_data_q;
    assign bus.wr_src  = wr_src_q;

endmodule

// File: tb/tb_register_write_arbiter.sv
// Directed and randomised checks of the round-robin write arbiter.
module tb_register_write_arbiter;

    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 32;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    register_write_arbiter_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) bus ();

    register_write_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          m_ptr;
        int          since_3;
        int          exp_idx;
        logic [3:0]  v;
        logic        st;
        logic [3:0]  exp_rdy;

        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.wr_stall  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) bus.req_data[i*WIDTH +: WIDTH] = 32'h1000_0000 + i;

        #2;
        chk("rst_en",   64'(bus.wr_en),   64'd0);
        chk("rst_data", 64'(bus.wr_data), 64'd0);
        chk("rst_src",  64'(bus.wr_src),  64'd0);

        @(negedge clk);
        rst = 1'b0;
        tick();

        // Rotation with all four valid from pointer 0
        bus.req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("rot_rdy", 64'(bus.req_ready), 64'(4'b0001 << (k % 4)));
            tick();
            chk("rot_en",   64'(bus.wr_en),   64'd1);
            chk("rot_src",  64'(bus.wr_src),  64'(k % 4));
            chk("rot_data", 64'(bus.wr_data), 64'(32'h1000_0000 + (k % 4)));
        end

        // Latency and data path, pointer 0 -> 3
        bus.req_valid = 4'b0100;
        bus.req_data[2*WIDTH +: WIDTH] = 32'hDEAD_BEEF;
        #1;
        chk("lat_rdy", 64'(bus.req_ready), 64'(4'b0100));
        tick();
        chk("lat_en",   64'(bus.wr_en),   64'd1);
        chk("lat_data", 64'(bus.wr_data), 64'hDEAD_BEEF);
        chk("lat_src",  64'(bus.wr_src),  64'd2);
        bus.req_valid = 4'b0000;
        #1;
        chk("idle_rdy", 64'(bus.req_ready), 64'd0);
        tick();
        chk("idle_en",   64'(bus.wr_en),   64'd0);
        chk("hold_data", 64'(bus.wr_data), 64'hDEAD_BEEF);
        chk("hold_src",  64'(bus.wr_src),  64'd2);

        // Wrap from pointer 3 with requesters 0 and 1
        bus.req_valid = 4'b0011;
        #1;
        chk("wrap_rdy0", 64'(bus.req_ready), 64'(4'b0001));
        tick();
        chk("wrap_src0", 64'(bus.wr_src), 64'd0);
        #1;
        chk("wrap_rdy1", 64'(bus.req_ready), 64'(4'b0010));
        tick();
        chk("wrap_src1", 64'(bus.wr_src), 64'd1);

        // Stall for three cycles; in-flight write from requester 1 still visible
        bus.req_valid = 4'b1010;
        bus.wr_stall  = 1'b1;
        #1;
        chk("stall_rdy", 64'(bus.req_ready), 64'd0);
        chk("drain_en",  64'(bus.wr_en),     64'd1);
        chk("drain_src", 64'(bus.wr_src),    64'd1);
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("stall_en", 64'(bus.wr_en), 64'd0);
            #1;
            chk("stall_rdy", 64'(bus.req_ready), 64'd0);
        end
        tick();
        chk("stall_en", 64'(bus.wr_en), 64'd0);
        bus.wr_stall = 1'b0;
        #1;
        chk("resume_rdy", 64'(bus.req_ready), 64'(4'b1000));
        tick();
        chk("resume_src",  64'(bus.wr_src),  64'd3);
        chk("resume_data", 64'(bus.wr_data), 64'h1000_0003);
        #1;
        chk("resume_rdy2", 64'(bus.req_ready), 64'(4'b0010));
        tick();
        chk("resume_src2", 64'(bus.wr_src), 64'd1);

        // Sole requester gets back-to-back writes
        bus.req_valid = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("sole_rdy", 64'(bus.req_ready), 64'(4'b0001));
            tick();
            chk("sole_en",  64'(bus.wr_en),  64'd1);
            chk("sole_src", 64'(bus.wr_src), 64'd0);
        end

        // Random traffic against a reference round-robin; requester 3 always valid
        m_ptr   = 1;
        since_3 = 0;
        for (int c = 0; c < 300; c++) begin
            v  = 4'($urandom_range(0, 15)) | 4'b1000;
            st = ($urandom_range(0, 3) == 0);
            bus.req_valid = v;
            bus.wr_stall  = st;
            exp_rdy = '0;
            exp_idx = -1;
            if (!st) begin
                for (int o = 0; o < NUM_REQ; o++) begin
                    if (exp_idx < 0 && v[(m_ptr + o) % NUM_REQ]) exp_idx = (m_ptr + o) % NUM_REQ;
                end
                exp_rdy[exp_idx] = 1'b1;
            end
            #1;
            chk("rnd_rdy", 64'(bus.req_ready), 64'(exp_rdy));
            tick();
            chk("rnd_en", 64'(bus.wr_en), 64'(exp_idx >= 0));
            if (exp_idx >= 0) begin
                chk("rnd_src", 64'(bus.wr_src), 64'(exp_idx));
                m_ptr   = (exp_idx + 1) % NUM_REQ;
                since_3 = (exp_idx == 3) ? 0 : since_3 + 1;
                chk("rnd_starve", 64'(since_3 < NUM_REQ), 64'd1);
            end
        end

        // Reset while a write is on the output port
        bus.req_valid = 4'b1111;
        bus.wr_stall  = 1'b0;
        tick();
        chk("pre_rst_en", 64'(bus.wr_en), 64'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_en",   64'(bus.wr_en),   64'd0);
        chk("mid_rst_data", 64'(bus.wr_data), 64'd0);
        chk("mid_rst_src",  64'(bus.wr_src),  64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_rdy", 64'(bus.req_ready), 64'(4'b0001));
        tick();
        chk("post_rst_en",  64'(bus.wr_en),  64'd1);
        chk("post_rst_src", 64'(bus.wr_src), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
